// File: rtl/avl_bus_txn_checker.sv
// Passive Avalon transaction checker: per-master command counters, read-in-flight tracking,
// sticky protocol error flags and optional worst-case read latency (AVL_CHK_LATENCY_EN).
module avl_bus_txn_checker #(
  parameter int MASTER_NUM      = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16,
  parameter int LAT_W           = 12,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic [MASTER_NUM-1:0]       m_read,
  input  logic [MASTER_NUM-1:0]       m_write,
  input  logic [MASTER_NUM-1:0]       m_request_ready,
  input  logic [MASTER_NUM-1:0]       m_read_data_valid,
  input  logic [MASTER_NUM-1:0]       m_resp_ready,
  input  logic                        clr,
  output logic [MASTER_NUM*CNT_W-1:0] rd_cmd_cnt,
  output logic [MASTER_NUM*CNT_W-1:0] wr_cmd_cnt,
  output logic [MASTER_NUM*OUT_W-1:0] outstanding,
  output logic [MASTER_NUM*LAT_W-1:0] max_rd_lat,
  output logic [MASTER_NUM-1:0]       err_orphan,
  output logic [MASTER_NUM-1:0]       err_overflow,
  output logic [MASTER_NUM-1:0]       err_rw_both,
  output logic                        err_multi_cmd,
  output logic                        any_err
);

  // Handshakes: a command transfers on a cycle where read/write and request_ready are both
  // high; a read response transfers where read_data_valid and resp_ready are both high.
  logic [MASTER_NUM-1:0] rd_acc;
  logic [MASTER_NUM-1:0] wr_acc;
  logic [MASTER_NUM-1:0] rsp_acc;
  logic [MASTER_NUM-1:0] cmd_any;
  logic                  multi_now;
  logic                  err_multi_q;

  assign rd_acc  = m_read & m_request_ready;
  assign wr_acc  = m_write & m_request_ready;
  assign rsp_acc = m_read_data_valid & m_resp_ready;
  assign cmd_any = rd_acc | wr_acc;

  // Clearing the lowest set bit leaves something only if two or more masters issued.
  assign multi_now = (cmd_any & (cmd_any - MASTER_NUM'(1))) != '0;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      err_multi_q <= 1'b0;
    end else if (clr) begin
      err_multi_q <= 1'b0;
    end else if (multi_now) begin
      err_multi_q <= 1'b1;
    end
  end

  assign err_multi_cmd = err_multi_q;
  assign any_err       = (|err_orphan) | (|err_overflow) | (|err_rw_both) | err_multi_q;

`ifdef AVL_CHK_LATENCY_EN
  logic [LAT_W-1:0] ts;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      ts <= '0;
    end else begin
      ts <= ts + LAT_W'(1);
    end
  end
`endif

  for (genvar i = 0; i < MASTER_NUM; i++) begin : g_m
    logic [OUT_W-1:0] cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             orph_q;
    logic             ovf_q;
    logic             rwb_q;
    logic             orphan;
    logic             overflow;
    logic             push;
    logic             pop;

    assign orphan   = rsp_acc[i] && (cnt == '0);
    // A full tracker only overflows when no response frees a slot in the same cycle.
    assign overflow = rd_acc[i] && !rsp_acc[i] && (cnt == OUT_W'(MAX_OUTSTANDING));
    assign pop      = rsp_acc[i] && !orphan;
    assign push     = rd_acc[i] && !overflow;

    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        cnt <= '0;
      end else begin
        case ({push, pop})
          2'b10:   cnt <= cnt + OUT_W'(1);
          2'b01:   cnt <= cnt - OUT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
        orph_q <= 1'b0;
        ovf_q  <= 1'b0;
        rwb_q  <= 1'b0;
      end else if (clr) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
        orph_q <= 1'b0;
        ovf_q  <= 1'b0;
        rwb_q  <= 1'b0;
      end else begin
        if (rd_acc[i] && (rd_cnt != '1)) rd_cnt <= rd_cnt + CNT_W'(1);
        if (wr_acc[i] && (wr_cnt != '1)) wr_cnt <= wr_cnt + CNT_W'(1);
        if (orphan) orph_q <= 1'b1;
        if (overflow) ovf_q <= 1'b1;
        if (rd_acc[i] && wr_acc[i]) rwb_q <= 1'b1;
      end
    end

    assign rd_cmd_cnt[i*CNT_W +: CNT_W]  = rd_cnt;
    assign wr_cmd_cnt[i*CNT_W +: CNT_W]  = wr_cnt;
    assign outstanding[i*OUT_W +: OUT_W] = cnt;
    assign err_orphan[i]                 = orph_q;
    assign err_overflow[i]               = ovf_q;
    assign err_rw_both[i]                = rwb_q;

`ifdef AVL_CHK_LATENCY_EN
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    logic [LAT_W-1:0] fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] max_lat;

    // Modulo subtraction keeps the latency correct across a timestamp wrap.
    assign lat = ts - fifo[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= ts;
    end

    always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        max_lat <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (clr) begin
          max_lat <= '0;
        end else if (pop && (lat > max_lat)) begin
          max_lat <= lat;
        end
      end
    end

    assign max_rd_lat[i*LAT_W +: LAT_W] = max_lat;
`else
    assign max_rd_lat[i*LAT_W +: LAT_W] = '0;
`endif
  end

endmodule
